// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    READING = 1'b1
  } state_e;

  localparam logic [31:0] OOR_WORD   = 32'hFFFF_FFFF;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed program store: one synchronous byte-write port and a
// combinational little-endian word read that returns OOR_WORD past the end.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [31:0]       rd_addr,
  output logic [31:0]       rd_word
);

  logic [7:0] mem_q [DEPTH];

  // No reset: program contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_word = OOR_WORD;
    if (({1'b0, rd_addr} + 33'd3) < 33'(DEPTH)) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        rd_word[8*b +: 8] = mem_q[rd_addr[ADDR_W-1:0] + ADDR_W'(b)];
      end
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// CPU fetch responder: multi-cycle miss with BUSYWAIT stall, zero-wait
// re-fetch through a one-word last-fetch register, byte-wide loader port.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [31:0]       ADDRESS,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic               last_valid_q, last_valid_d;
  logic [31:0]        last_addr_q, last_addr_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0] waddr;
  logic [31:0] load_waddr;
  logic [31:0] arr_word;
  logic [31:0] fill_word;
  logic        hit;

  assign waddr      = {ADDRESS[31:2], 2'b00};
  assign load_waddr = {{(32-ADDR_W){1'b0}}, LOAD_ADDR[ADDR_W-1:2], 2'b00};
  assign hit        = last_valid_q && (waddr == last_addr_q);

  imem_byte_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (CLK),
    .wr_en   (LOAD_EN),
    .wr_addr (LOAD_ADDR),
    .wr_data (LOAD_DATA),
    .rd_addr (req_addr_q),
    .rd_word (arr_word)
  );

  // A loader byte landing on the completion edge must appear in the returned word.
  always_comb begin
    fill_word = arr_word;
    if (LOAD_EN && (load_waddr == req_addr_q)) begin
      fill_word[{LOAD_ADDR[1:0], 3'b000} +: 8] = LOAD_DATA;
    end
  end

  assign BUSYWAIT    = (state_q == READING) || (READ && !hit);
  assign INSTRUCTION = instr_q;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;

    if (LOAD_EN && (load_waddr == last_addr_q)) begin
      last_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (READ && !hit) begin
          req_addr_d = waddr;
          cnt_d      = CNT_INIT;
          state_d    = READING;
        end
      end
      READING: begin
        // Completion overrides any same-edge invalidation of the old word.
        if (cnt_q == '0) begin
          instr_d      = fill_word;
          last_addr_d  = req_addr_q;
          last_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      instr_q      <= 32'h0;
      last_valid_q <= 1'b0;
      last_addr_q  <= 32'h0;
      req_addr_q   <= 32'h0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder against a transaction-level
// model (byte memory image, last-fetch tag, expected stall length).
module tb_imem_fetch_responder;

  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 4;

  logic              CLK       = 1'b0;
  logic              RESET     = 1'b0;
  logic              READ      = 1'b0;
  logic [31:0]       ADDRESS   = 32'h0;
  logic              LOAD_EN   = 1'b0;
  logic [ADDR_W-1:0] LOAD_ADDR = '0;
  logic [7:0]        LOAD_DATA = 8'h0;
  logic [31:0]       INSTRUCTION;
  logic              BUSYWAIT;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem_m [DEPTH];
  logic        last_valid_m = 1'b0;
  logic [31:0] last_addr_m  = 32'h0;
  logic [31:0] instr_m      = 32'h0;

  imem_fetch_responder #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .READ        (READ),
    .ADDRESS     (ADDRESS),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .LOAD_EN     (LOAD_EN),
    .LOAD_ADDR   (LOAD_ADDR),
    .LOAD_DATA   (LOAD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    int          i;
    w = {a[31:2], 2'b00};
    if (longint'(w) + 3 >= longint'(DEPTH)) return 32'hFFFF_FFFF;
    i = int'(w);
    return {mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic load_byte(input int a, input logic [7:0] d);
    READ      = 1'b0;
    LOAD_EN   = 1'b1;
    LOAD_ADDR = ADDR_W'(a);
    LOAD_DATA = d;
    @(posedge CLK); #1;
    LOAD_EN = 1'b0;
    mem_m[a] = d;
    if (last_valid_m && ({a[31:2], 2'b00} == last_addr_m)) last_valid_m = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    logic [31:0] w;
    logic        hit;
    int          cyc;
    w   = {a[31:2], 2'b00};
    hit = last_valid_m && (w == last_addr_m);
    cyc = 0;
    READ    = 1'b1;
    ADDRESS = a;
    #1;
    while (BUSYWAIT === 1'b1 && cyc < LATENCY + 8) begin
      cyc++;
      @(posedge CLK); #1;
    end
    if (!hit) begin
      instr_m      = model_word(w);
      last_addr_m  = w;
      last_valid_m = 1'b1;
    end
    check_eq({tag, "_stall"}, 32'(cyc), hit ? 32'd0 : 32'(LATENCY + 1));
    check_eq({tag, "_word"}, INSTRUCTION, instr_m);
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(BUSYWAIT), 32'd0);
    check_eq("rst_instr", INSTRUCTION, 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < DEPTH; i++) load_byte(i, 8'($urandom_range(0, 255)));
    load_byte(0, 8'h05);
    load_byte(1, 8'h01);
    load_byte(2, 8'h02);
    load_byte(3, 8'h00);

    fetch(32'd0, "w0");
    check_eq("w0_const", INSTRUCTION, 32'h0002_0105);
    fetch(32'd2, "w0_hit");
    fetch(32'd4, "w4");
    fetch(32'd0, "w0_again");
    load_byte(1, 8'hAA);
    fetch(32'd0, "w0_reload");
    check_eq("w0_aa", INSTRUCTION, 32'h0002_AA05);

    // Address changes mid-miss: completion returns word 4, then 8 misses.
    READ    = 1'b1;
    ADDRESS = 32'd4;
    #1;
    check_eq("sw_c0_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    ADDRESS = 32'd8;
    repeat (LATENCY - 1) begin
      #1;
      check_eq("sw_busy", 32'(BUSYWAIT), 32'd1);
      @(posedge CLK); #1;
    end
    instr_m      = model_word(32'd4);
    last_addr_m  = 32'd4;
    last_valid_m = 1'b1;
    #1;
    check_eq("sw_word", INSTRUCTION, instr_m);
    check_eq("sw_next_busy", 32'(BUSYWAIT), 32'd1);
    fetch(32'd8, "w8");

    fetch(32'(DEPTH), "oor");
    check_eq("oor_const", INSTRUCTION, 32'hFFFF_FFFF);
    fetch(32'(DEPTH - 4), "last_word");
    fetch(32'hFFFF_FFFE, "top");

    // Loader write landing on the completion edge of a miss.
    READ    = 1'b1;
    ADDRESS = 32'd12;
    #1;
    for (int c = 0; c <= LATENCY; c++) begin
      check_eq("se_busy", 32'(BUSYWAIT), 32'd1);
      if (c == LATENCY) begin
        LOAD_EN   = 1'b1;
        LOAD_ADDR = ADDR_W'(14);
        LOAD_DATA = 8'h5A;
        mem_m[14] = 8'h5A;
      end
      @(posedge CLK); #1;
      LOAD_EN = 1'b0;
    end
    instr_m      = model_word(32'd12);
    last_addr_m  = 32'd12;
    last_valid_m = 1'b1;
    #1;
    check_eq("se_hit_busy", 32'(BUSYWAIT), 32'd0);
    check_eq("se_word", INSTRUCTION, instr_m);
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of a miss.
    READ    = 1'b1;
    ADDRESS = 32'd20;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    READ  = 1'b0;
    RESET = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(BUSYWAIT), 32'd0);
    check_eq("mid_rst_instr", INSTRUCTION, 32'h0);
    last_valid_m = 1'b0;
    instr_m      = 32'h0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    fetch(32'd12, "post_rst");

    for (int n = 0; n < 80; n++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 14);
      if (r >= 12) begin
        load_byte($urandom_range(0, 35), 8'($urandom_range(0, 255)));
      end else begin
        case (r)
          8:       a = 32'(DEPTH - 4 + $urandom_range(0, 3));
          9:       a = 32'(DEPTH + $urandom_range(0, 15));
          10:      a = $urandom;
          11:      a = last_addr_m | 32'($urandom_range(0, 3));
          default: a = 32'(r * 4 + $urandom_range(0, 3));
        endcase
        fetch(a, "rand");
        if ($urandom_range(0, 3) == 0) begin
          READ = 1'b0;
          @(posedge CLK); #1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
